// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the 16-bit processor. Owns the PC, reads instruction words
// from instruction memory with a req/ack handshake, registers each word and
// hands it to decode with a valid/ready handshake.
//
// Handshakes:
//   imem side : imem_req is held high with a stable imem_addr until the cycle
//               in which imem_ack is seen. A request is never withdrawn except
//               by reset.
//   decode    : if_valid/instr/pc_out stay stable until the cycle where
//               if_valid && if_ready. The transfer happens on that rising edge.
//
// Ports:
//   clock, reset_n     clock; asynchronous active-low reset
//   imem_req/addr      instruction-memory read request and word address
//   imem_ack/rdata     memory response (rdata valid while ack=1)
//   if_valid/if_ready  handshake to decode
//   instr, opcode      registered instruction word and its top nibble
//   pc_out, pc_plus1   address of instr and that address + 1 (wraps)
//   redirect/_pc       one-cycle branch redirect and its target
//   halted             fetch stopped after delivering a HALT_OP instruction
//   fsm_state          debug view of the FSM (0=IDLE 1=REQ 2=HOLD 3=HALTED)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0]   instr_q,    instr_d;
    logic [ADDR_W-1:0]   pc_out_q,   pc_out_d;
    logic                valid_q,    valid_d;
    logic                halted_q,   halted_d;
    // A redirect seen while a request is outstanding cannot move imem_addr
    // (the request must stay stable), so the target is parked here until ack.
    logic                pend_q,     pend_d;
    logic [ADDR_W-1:0]   pend_pc_q,  pend_pc_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= RESET_PC;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) fetch_pc_d = redirect_pc;
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Same-cycle redirect beats any parked target.
                        fetch_pc_d = redirect_pc;
                        pend_d     = 1'b0;
                    end else if (pend_q) begin
                        fetch_pc_d = pend_pc_q;
                        pend_d     = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = fetch_pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if (redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    // Squash the held word even if decode is taking it now.
                    valid_d    = 1'b0;
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (if_ready) begin
                    valid_d = 1'b0;
                    if (instr_q[DATA_W-1 -: 4] == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        fetch_pc_d = pc_out_q + PC_ONE;
                        state_d    = S_REQ;
                    end
                end
            end

            S_HALTED: begin
                if (redirect) begin
                    halted_d   = 1'b0;
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Request is decoded from the state register so an async reset drops it
    // immediately, without waiting for a clock edge.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = valid_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[DATA_W-1 -: 4];
    assign pc_out    = pc_out_q;
    assign pc_plus1  = pc_out_q + PC_ONE;
    assign halted    = halted_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. All inputs are driven and all outputs sampled
// on the falling clock edge; the DUT only changes state on the rising edge.
// A second instance with RESET_PC=16'hFFFF exercises PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // main instance, RESET_PC = 0
  logic        imem_req, imem_ack, if_valid, if_ready, redirect, halted;
  logic [15:0] imem_addr, imem_rdata, instr, pc_out, pc_plus1, redirect_pc;
  logic [3:0]  opcode;
  logic [1:0]  dbg_state;

  // wrap instance, RESET_PC = 16'hFFFF
  logic        w_req, w_ack, w_valid, w_ready, w_redirect, w_halted;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc_out, w_pc_plus1, w_redirect_pc;
  logic [3:0]  w_opcode;
  logic [1:0]  w_state;

  instruction_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .HALT_OP(4'hF)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .fsm_state(dbg_state)
  );

  instruction_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF), .HALT_OP(4'hF)) u_wrap (
    .clock(clock), .reset_n(reset_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_ready(w_ready), .instr(w_instr), .opcode(w_opcode),
    .pc_out(w_pc_out), .pc_plus1(w_pc_plus1), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .halted(w_halted), .fsm_state(w_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory responder
  logic [15:0] mem [0:255];
  bit          auto_mem;
  int          wcnt, cur_wait, max_wait;

  task automatic step();
    @(negedge clock);
    if (auto_mem) begin
      if (imem_req) begin
        if (wcnt >= cur_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[7:0]];
          wcnt       = 0;
          cur_wait   = $urandom_range(0, max_wait);
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    auto_mem    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    if_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    w_ack       = 1'b0;
    w_rdata     = '0;
    w_ready     = 1'b0;
    w_redirect  = 1'b0;
    w_redirect_pc = '0;
    wcnt        = 0;
    cur_wait    = 0;
    max_wait    = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic        cd;       // compare instr/opcode/pc_out/pc_plus1 on this row
    logic [15:0] e_instr;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tbl [21];

  logic [15:0] exp_q [$];

  initial begin
    // ack rdata ready redir rpc | req addr valid cd instr pc
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h0000};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 16'h2ABC, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h2ABC, 16'h0001};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[14] = '{1'b1, 16'h3333, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[15] = '{1'b1, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b1, 1'b1, 16'h4444, 16'h0040};
    tbl[17] = '{1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b1, 16'h5555, 16'h0040};
    tbl[19] = '{1'b1, 16'h6666, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000};

    // ---------------- table-driven sequence ----------------
    do_reset();
    chk("reset_state_idle", {30'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("t%0d_req", i),    {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("t%0d_addr", i),   {16'd0, imem_addr}, {16'd0, tbl[i].e_addr});
      chk($sformatf("t%0d_valid", i),  {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("t%0d_halted", i), {31'd0, halted}, 32'd0);
      if (tbl[i].cd) begin
        chk($sformatf("t%0d_instr", i),  {16'd0, instr},  {16'd0, tbl[i].e_instr});
        chk($sformatf("t%0d_opcode", i), {28'd0, opcode}, {28'd0, tbl[i].e_instr[15:12]});
        chk($sformatf("t%0d_pc", i),     {16'd0, pc_out}, {16'd0, tbl[i].e_pc});
        chk($sformatf("t%0d_pcp1", i),   {16'd0, pc_plus1}, {16'd0, tbl[i].e_pc + 16'd1});
      end
      imem_ack    = tbl[i].ack;
      imem_rdata  = tbl[i].rdata;
      if_ready    = tbl[i].ready;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(negedge clock);
    end

    // ---------------- PC wrap (second instance) ----------------
    do_reset();
    w_ack   = 1'b1;
    w_rdata = 16'h1111;
    @(negedge clock);
    chk("wrap_req", {31'd0, w_req}, 32'd1);
    chk("wrap_addr_first", {16'd0, w_addr}, 32'hFFFF);
    @(negedge clock);
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_pc_out", {16'd0, w_pc_out}, 32'hFFFF);
    chk("wrap_pc_plus1", {16'd0, w_pc_plus1}, 32'h0000);
    w_ready = 1'b1;
    @(negedge clock);
    chk("wrap_next_addr", {16'd0, w_addr}, 32'h0000);
    chk("wrap_next_req", {31'd0, w_req}, 32'd1);

    // ---------------- HALT and restart by redirect ----------------
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[5]   = 16'hF000;
    auto_mem = 1'b1;
    if_ready = 1'b1;
    begin
      bit found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
        step();
        if (if_valid && pc_out == 16'd5) found = 1'b1;
      end
      chk("halt_delivered", {31'd0, found}, 32'd1);
    end
    chk("halt_opcode", {28'd0, opcode}, 32'hF);
    chk("halt_instr", {16'd0, instr}, 32'hF000);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("halted_flag", {31'd0, halted}, 32'd1);
      chk("halted_req", {31'd0, imem_req}, 32'd0);
      chk("halted_valid", {31'd0, if_valid}, 32'd0);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0002;
    step();
    redirect = 1'b0;
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    chk("unhalt_addr", {16'd0, imem_addr}, 32'h0002);
    step();
    chk("unhalt_valid", {31'd0, if_valid}, 32'd1);
    chk("unhalt_pc", {16'd0, pc_out}, 32'h0002);
    chk("unhalt_instr", {16'd0, instr}, 32'h0102);

    // ---------------- randomized run vs in-order reference ----------------
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[i]);
    auto_mem = 1'b1;
    max_wait = 3;
    cur_wait = $urandom_range(0, 3);
    begin
      int          got = 0;
      logic [15:0] model_pc = 16'h0000;
      bit          prev_wait = 1'b0, prev_stall = 1'b0;
      logic [15:0] prev_addr = '0, prev_instr = '0, prev_pc = '0;
      logic [15:0] exp_w;
      for (int c = 0; c < 4000 && got < 150; c++) begin
        step();
        if (prev_wait) begin
          chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
          chk("rnd_addr_held", {16'd0, imem_addr}, {16'd0, prev_addr});
        end
        if (prev_stall) begin
          chk("rnd_valid_held", {31'd0, if_valid}, 32'd1);
          chk("rnd_instr_held", {16'd0, instr}, {16'd0, prev_instr});
          chk("rnd_pc_held", {16'd0, pc_out}, {16'd0, prev_pc});
        end
        if_ready = ($urandom_range(0, 9) < 6);
        if (if_valid && if_ready) begin
          exp_w = exp_q.pop_front();
          chk("rnd_instr", {16'd0, instr}, {16'd0, exp_w});
          chk("rnd_pc", {16'd0, pc_out}, {16'd0, model_pc});
          chk("rnd_pc_plus1", {16'd0, pc_plus1}, {16'd0, model_pc + 16'd1});
          model_pc++;
          got++;
        end
        prev_wait  = imem_req && !imem_ack;
        prev_addr  = imem_addr;
        prev_stall = if_valid && !if_ready;
        prev_instr = instr;
        prev_pc    = pc_out;
      end
      chk("rnd_completed", got, 150);
    end

    // ---------------- asynchronous reset mid-transaction ----------------
    do_reset();
    auto_mem = 1'b1;
    cur_wait = 50;
    step();
    step();
    chk("areset_pre_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_req", {31'd0, imem_req}, 32'd0);
    chk("areset_valid", {31'd0, if_valid}, 32'd0);

    do_reset();
    auto_mem = 1'b1;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        step();
        if (if_valid) seen = 1'b1;
      end
      chk("areset_hold_seen", {31'd0, seen}, 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_hold_valid", {31'd0, if_valid}, 32'd0);
    chk("areset_hold_req", {31'd0, imem_req}, 32'd0);
    chk("areset_hold_pc", {16'd0, pc_out}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the 16-bit processor, directly upstream of the control unit.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Registers each fetched word and presents it to decode; the opcode field drives the control unit's 4-bit opcode input.
- Accepts branch redirects and stops fetching after a HALT opcode.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width (word addressed)
- DATA_W, 16, instruction width
- RESET_PC, 16'h0000, first fetch address after reset
- HALT_OP, 4'b1111, opcode that stops fetching after it is delivered

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- imem_req  output  1  instruction-memory read request
- imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
- imem_ack  input  1  memory has imem_rdata valid this cycle
- imem_rdata  input  DATA_W  fetched instruction word
- if_valid  output  1  instr/pc_out hold a valid instruction
- if_ready  input  1  decode accepts the instruction this cycle
- instr  output  DATA_W  registered instruction word
- opcode  output  4  instr[15:12], to control unit
- pc_out  output  ADDR_W  address of instr
- pc_plus1  output  ADDR_W  pc_out+1, modulo 2^ADDR_W
- redirect  input  1  branch taken; valid for one cycle
- redirect_pc  input  ADDR_W  branch target
- halted  output  1  fetch stopped by HALT_OP

Behaviour:
- Reset (async assert, sync release) forces these values:
  - imem_req=0, imem_addr=RESET_PC
  - if_valid=0, instr=0, pc_out=RESET_PC
  - halted=0, redirect-pending flag=0
  - state=IDLE
- State IDLE: the first cycle after reset release goes to REQ.
- State REQ:
  - imem_req=1 with imem_addr=fetch PC.
  - Address and req are held unchanged until imem_ack. A request is never withdrawn.
  - On ack with no pending/concurrent redirect:
    - instr<=imem_rdata, pc_out<=fetch PC, if_valid<=1.
    - Next state is HOLD.
- State HOLD:
  - imem_req=0; if_valid=1 and instr is held stable until if_ready.
  - On if_valid&if_ready:
    - If opcode==HALT_OP: go to HALTED.
    - Otherwise: fetch PC<=pc_out+1 and go to REQ.
    - if_valid drops in the same edge.
- State HALTED: imem_req=0, if_valid=0, halted=1. The state is left only by reset or redirect.
- Throughput: at most one instruction per 2 cycles with a zero-wait memory.
- Minimum latency from the req cycle (with same-cycle ack) to if_valid is 1 cycle.
- PC wraps: 16'hFFFF+1=16'h0000, for both fetch PC and pc_plus1.
- Redirect rules (redirect has priority over all other events):
  - In REQ without ack: latch redirect_pc and set the pending flag. On the eventual ack the word is discarded (if_valid stays 0), then REQ at the latched target.
  - In REQ with ack in the same cycle: the word is discarded, then REQ at redirect_pc.
  - In HOLD: if_valid<=0 (the instruction is squashed even if if_ready=1 this cycle), then REQ at redirect_pc.
  - In HALTED: halted<=0, then REQ at redirect_pc.
  - A second redirect while pending overwrites the latched target (last wins).
- Reset mid-transaction: imem_req drops immediately (async). The memory side must tolerate an abandoned request.
- When if_valid=0, opcode reflects instr[15:12]; decode must qualify it with if_valid.

Test Plan:
- Reset with RESET_PC=0, memory acks in the req cycle, mem[0]=16'h1234, if_ready=1:
  - imem_req rises in the 1st cycle after release.
  - Next cycle: if_valid=1, instr=16'h1234, opcode=4'h1, pc_out=0, pc_plus1=1.
  - Next fetch address is 1.
- Memory with 3 wait states:
  - imem_addr stays at 0 and imem_req stays 1 for 4 cycles.
  - if_valid rises only after the ack cycle.
- if_ready=0 for 5 cycles with a valid instruction:
  - instr and pc_out stay stable.
  - imem_req=0 throughout; no address advance.
- Redirect in each case, target 16'h0040:
  - During the wait-state REQ: the fetched word is dropped and the next imem_addr=16'h0040.
  - During HOLD with if_ready=1: if_valid clears and the next imem_addr=16'h0040.
- mem[5]=16'hF000:
  - Delivered with if_valid=1, opcode=4'hF.
  - After acceptance: halted=1 and imem_req stays 0.
  - Redirect to 16'h0002 clears halted and fetches address 2.
- PC wrap: RESET_PC=16'hFFFF; after acceptance the next fetch address is 16'h0000 and pc_plus1=16'h0000.
- Async reset asserted mid-REQ: imem_req=0 and if_valid=0 immediately, without waiting for a clock edge.
